// File: rtl/fifo_wr_sched_pkg.sv
// Shared constants, types and the round-robin pick function for the multi-producer FIFO scheduler.
// Optional status outputs are enabled with FIFO_WR_SCHED_STATUS_EN.
package fifo_wr_sched_pkg;

    localparam int NUM_REQ      = 4;
    localparam int DATA_W       = 8;
    localparam int DEPTH        = 8;
    localparam int PTR_SIZE     = 3;
    localparam int AFULL_THRESH = 6;
    localparam int GID_W        = $clog2(NUM_REQ);

    typedef logic [PTR_SIZE-1:0]       ptr_t;
    typedef logic [PTR_SIZE:0]         cnt_t;
    typedef logic [GID_W-1:0]          gid_t;
    typedef logic [NUM_REQ-1:0]        req_t;
    typedef logic [DATA_W-1:0]         data_t;
    typedef logic [NUM_REQ*DATA_W-1:0] bus_data_t;

    // One-hot grant of the first asserted request after 'last', wrapping at NUM_REQ.
    function automatic req_t rr_pick(req_t req, gid_t last);
        req_t grant;
        logic found;
        gid_t idx;
        grant = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = gid_t'((32'(last) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/fifo_wr_sched_if.sv
// Producer/consumer/storage signal bundle for fifo_wr_sched.
// occupancy and almost_full exist only with FIFO_WR_SCHED_STATUS_EN.
interface fifo_wr_sched_if;
    import fifo_wr_sched_pkg::*;

    req_t      req_valid;
    bus_data_t req_data;
    req_t      req_ready;
    logic      rd_req;
    logic      wr_en;
    ptr_t      wr_ptr;
    data_t     wr_data;
    logic      rd_en;
    ptr_t      rd_ptr;
    gid_t      grant_id;
    logic      full;
    logic      empty;
`ifdef FIFO_WR_SCHED_STATUS_EN
    cnt_t      occupancy;
    logic      almost_full;

    modport master (
        output req_valid, req_data, rd_req,
        input  req_ready, wr_en, wr_ptr, wr_data, rd_en, rd_ptr, grant_id,
               full, empty, occupancy, almost_full
    );

    modport slave (
        input  req_valid, req_data, rd_req,
        output req_ready, wr_en, wr_ptr, wr_data, rd_en, rd_ptr, grant_id,
               full, empty, occupancy, almost_full
    );
`else
    modport master (
        output req_valid, req_data, rd_req,
        input  req_ready, wr_en, wr_ptr, wr_data, rd_en, rd_ptr, grant_id,
               full, empty
    );

    modport slave (
        input  req_valid, req_data, rd_req,
        output req_ready, wr_en, wr_ptr, wr_data, rd_en, rd_ptr, grant_id,
               full, empty
    );
`endif

endinterface

// File: rtl/fifo_wr_sched_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant plus index, remembering the last winner.
module rr_arbiter
    import fifo_wr_sched_pkg::*;
(
    input  logic clk_in,
    input  logic sreset,
    input  req_t req,
    input  logic mask_en,
    output req_t grant,
    output gid_t grant_id
);

    gid_t last_grant;

    always_comb begin
        grant = '0;
        if (mask_en) begin
            grant = rr_pick(req, last_grant);
        end
    end

    always_comb begin
        grant_id = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_id = gid_t'(i);
            end
        end
    end

    // Starting at NUM_REQ-1 makes producer 0 the first winner after reset.
    always_ff @(posedge clk_in) begin
        if (sreset) begin
            last_grant <= gid_t'(NUM_REQ - 1);
        end else if (|grant) begin
            last_grant <= grant_id;
        end
    end

endmodule

// File: rtl/fifo_wr_sched.sv
// Multi-producer FIFO write scheduler: round-robin write-port sharing, read sequencing, pointers and flags.
// Define FIFO_WR_SCHED_STATUS_EN to add occupancy and registered almost_full outputs.
module fifo_wr_sched
    import fifo_wr_sched_pkg::*;
(
    input logic            clk_in,
    input logic            sreset,
    fifo_wr_sched_if.slave bus
);

    req_t  grant;
    gid_t  grant_id;
    ptr_t  wr_ptr_q;
    ptr_t  rd_ptr_q;
    cnt_t  count;
    cnt_t  count_next;
    logic  full_q;
    logic  empty_q;
    logic  wr_fire;
    logic  rd_fire;
    data_t wr_data_mux;

    rr_arbiter u_arb (
        .clk_in   (clk_in),
        .sreset   (sreset),
        .req      (bus.req_valid),
        .mask_en  (~full_q),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign wr_fire = |grant;
    // Gated by the registered empty flag, so a write into an empty FIFO never reads through.
    assign rd_fire = bus.rd_req & ~empty_q;

    always_comb begin
        wr_data_mux = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                wr_data_mux = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        count_next = count;
        case ({wr_fire, rd_fire})
            2'b10:   count_next = count + cnt_t'(1);
            2'b01:   count_next = count - cnt_t'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (sreset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (wr_fire) begin
                wr_ptr_q <= wr_ptr_q + ptr_t'(1);
            end
            if (rd_fire) begin
                rd_ptr_q <= rd_ptr_q + ptr_t'(1);
            end
            count   <= count_next;
            full_q  <= (count_next == cnt_t'(DEPTH));
            empty_q <= (count_next == '0);
        end
    end

`ifdef FIFO_WR_SCHED_STATUS_EN
    logic afull_q;

    always_ff @(posedge clk_in) begin
        if (sreset) begin
            afull_q <= 1'b0;
        end else begin
            afull_q <= (count_next >= cnt_t'(AFULL_THRESH));
        end
    end

    assign bus.occupancy   = count;
    assign bus.almost_full = afull_q;
`endif

    assign bus.req_ready = grant;
    assign bus.wr_en     = wr_fire;
    assign bus.wr_ptr    = wr_ptr_q;
    assign bus.wr_data   = wr_data_mux;
    assign bus.grant_id  = grant_id;
    assign bus.rd_en     = rd_fire;
    assign bus.rd_ptr    = rd_ptr_q;
    assign bus.full      = full_q;
    assign bus.empty     = empty_q;

endmodule

// File: tb/tb_fifo_wr_sched.sv
// Directed self-checking bench for fifo_wr_sched with hand-computed expectations.
module tb_fifo_wr_sched;
    import fifo_wr_sched_pkg::*;

    logic clk;
    logic sreset;
    int   checks;
    int   errors;

    fifo_wr_sched_if bus();

    fifo_wr_sched dut (
        .clk_in (clk),
        .sreset (sreset),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        sreset        = 1'b1;
        bus.req_valid = '0;
        bus.rd_req    = 1'b0;
        @(posedge clk);
        #1;
        sreset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0h want 1", bus.empty); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %0h want 0", bus.full); end
        checks++; if (bus.wr_ptr !== 3'd0) begin errors++; $display("FAIL reset_wr_ptr got %0d want 0", bus.wr_ptr); end
        checks++; if (bus.rd_ptr !== 3'd0) begin errors++; $display("FAIL reset_rd_ptr got %0d want 0", bus.rd_ptr); end
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b want 0000", bus.req_ready); end
        checks++; if (bus.rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en_on_empty got %0h want 0", bus.rd_en); end
`ifdef FIFO_WR_SCHED_STATUS_EN
        checks++; if (bus.occupancy !== 4'd0) begin errors++; $display("FAIL reset_occupancy got %0d want 0", bus.occupancy); end
        checks++; if (bus.almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full got %0h want 0", bus.almost_full); end
`endif
        @(negedge clk);
        bus.req_valid = 4'b1111;
        #1;
        checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL reset_first_grant got %0d want 0", bus.grant_id); end
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_ready got %b want 0001", bus.req_ready); end
        bus.req_valid = '0;
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_data;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.req_valid = 4'b1111;
            #1;
            exp_data = 8'hA0 + 8'(i);
            checks++; if (bus.grant_id !== 2'(i)) begin errors++; $display("FAIL rr_grant_id[%0d] got %0d want %0d", i, bus.grant_id, i); end
            checks++; if (bus.req_ready !== 4'(1 << i)) begin errors++; $display("FAIL rr_req_ready[%0d] got %b want %b", i, bus.req_ready, 4'(1 << i)); end
            checks++; if (bus.wr_en !== 1'b1) begin errors++; $display("FAIL rr_wr_en[%0d] got %0h want 1", i, bus.wr_en); end
            checks++; if (bus.wr_ptr !== 3'(i)) begin errors++; $display("FAIL rr_wr_ptr[%0d] got %0d want %0d", i, bus.wr_ptr, i); end
            checks++; if (bus.wr_data !== exp_data) begin errors++; $display("FAIL rr_wr_data[%0d] got %0h want %0h", i, bus.wr_data, exp_data); end
            @(posedge clk);
            #1;
        end
        bus.req_valid = '0;
        checks++; if (bus.wr_ptr !== 3'd4) begin errors++; $display("FAIL rr_final_wr_ptr got %0d want 4", bus.wr_ptr); end
        checks++; if (bus.empty !== 1'b0) begin errors++; $display("FAIL rr_empty got %0h want 0", bus.empty); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL rr_full got %0h want 0", bus.full); end
`ifdef FIFO_WR_SCHED_STATUS_EN
        checks++; if (bus.occupancy !== 4'd4) begin errors++; $display("FAIL rr_occupancy got %0d want 4", bus.occupancy); end
`endif
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.req_valid = 4'b1111;
            #1;
            checks++; if (bus.grant_id !== 2'(i % 4)) begin errors++; $display("FAIL fill_grant_id[%0d] got %0d want %0d", i, bus.grant_id, i % 4); end
            @(posedge clk);
            #1;
            if (i == 6) begin
                checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL fill_full_at7 got %0h want 0", bus.full); end
            end
        end
        checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL fill_full got %0h want 1", bus.full); end
        checks++; if (bus.wr_ptr !== 3'd0) begin errors++; $display("FAIL fill_wr_ptr_wrap got %0d want 0", bus.wr_ptr); end
`ifdef FIFO_WR_SCHED_STATUS_EN
        checks++; if (bus.occupancy !== 4'd8) begin errors++; $display("FAIL fill_occupancy got %0d want 8", bus.occupancy); end
        checks++; if (bus.almost_full !== 1'b1) begin errors++; $display("FAIL fill_almost_full got %0h want 1", bus.almost_full); end
`endif
        @(negedge clk);
        #1;
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL fill_req_ready_c9 got %b want 0000", bus.req_ready); end
        checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL fill_wr_en_c9 got %0h want 0", bus.wr_en); end
        @(posedge clk);
        #1;
        checks++; if (bus.wr_ptr !== 3'd0) begin errors++; $display("FAIL fill_no_overflow_ptr got %0d want 0", bus.wr_ptr); end
        checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL fill_still_full got %0h want 1", bus.full); end
    endtask

    // Continues from the full state left by test_fill (last winner is producer 3).
    task automatic test_full_read();
        @(negedge clk);
        bus.req_valid = 4'b0100;
        bus.rd_req    = 1'b1;
        #1;
        checks++; if (bus.rd_en !== 1'b1) begin errors++; $display("FAIL fullrd_rd_en got %0h want 1", bus.rd_en); end
        checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL fullrd_wr_en got %0h want 0", bus.wr_en); end
        checks++; if (bus.rd_ptr !== 3'd0) begin errors++; $display("FAIL fullrd_rd_ptr got %0d want 0", bus.rd_ptr); end
        @(posedge clk);
        #1;
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL fullrd_full_cleared got %0h want 0", bus.full); end
        checks++; if (bus.rd_ptr !== 3'd1) begin errors++; $display("FAIL fullrd_rd_ptr_adv got %0d want 1", bus.rd_ptr); end
        @(negedge clk);
        bus.rd_req = 1'b0;
        #1;
        checks++; if (bus.wr_en !== 1'b1) begin errors++; $display("FAIL fullrd_resume_wr_en got %0h want 1", bus.wr_en); end
        checks++; if (bus.grant_id !== 2'd2) begin errors++; $display("FAIL fullrd_grant_id got %0d want 2", bus.grant_id); end
        checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL fullrd_req_ready got %b want 0100", bus.req_ready); end
        checks++; if (bus.wr_data !== 8'hA2) begin errors++; $display("FAIL fullrd_wr_data got %0h want a2", bus.wr_data); end
        checks++; if (bus.wr_ptr !== 3'd0) begin errors++; $display("FAIL fullrd_wr_ptr got %0d want 0", bus.wr_ptr); end
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL fullrd_refull got %0h want 1", bus.full); end
        checks++; if (bus.wr_ptr !== 3'd1) begin errors++; $display("FAIL fullrd_wr_ptr_adv got %0d want 1", bus.wr_ptr); end
    endtask

    task automatic test_empty_both();
        do_reset();
        @(negedge clk);
        bus.req_valid = 4'b0010;
        bus.rd_req    = 1'b1;
        #1;
        checks++; if (bus.wr_en !== 1'b1) begin errors++; $display("FAIL emp_wr_en got %0h want 1", bus.wr_en); end
        checks++; if (bus.rd_en !== 1'b0) begin errors++; $display("FAIL emp_rd_en got %0h want 0", bus.rd_en); end
        checks++; if (bus.grant_id !== 2'd1) begin errors++; $display("FAIL emp_grant_id got %0d want 1", bus.grant_id); end
        checks++; if (bus.wr_data !== 8'hA1) begin errors++; $display("FAIL emp_wr_data got %0h want a1", bus.wr_data); end
        @(posedge clk);
        #1;
        checks++; if (bus.empty !== 1'b0) begin errors++; $display("FAIL emp_empty got %0h want 0", bus.empty); end
        checks++; if (bus.wr_ptr !== 3'd1) begin errors++; $display("FAIL emp_wr_ptr got %0d want 1", bus.wr_ptr); end
        checks++; if (bus.rd_ptr !== 3'd0) begin errors++; $display("FAIL emp_rd_ptr got %0d want 0", bus.rd_ptr); end
`ifdef FIFO_WR_SCHED_STATUS_EN
        checks++; if (bus.occupancy !== 4'd1) begin errors++; $display("FAIL emp_occupancy got %0d want 1", bus.occupancy); end
`endif
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        checks++; if (bus.rd_en !== 1'b1) begin errors++; $display("FAIL emp_pop_rd_en got %0h want 1", bus.rd_en); end
        checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL emp_idle_wr_en got %0h want 0", bus.wr_en); end
        @(posedge clk);
        #1;
        bus.rd_req = 1'b0;
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL emp_drained got %0h want 1", bus.empty); end
        checks++; if (bus.rd_ptr !== 3'd1) begin errors++; $display("FAIL emp_rd_ptr_adv got %0d want 1", bus.rd_ptr); end
    endtask

    // Continues from test_empty_both: empty, both pointers at 1, last winner producer 1.
    task automatic test_back_to_back();
        @(negedge clk);
        bus.req_valid = 4'b0001;
        #1;
        checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL b2b_wrap_grant got %0d want 0", bus.grant_id); end
        @(posedge clk);
        #1;
        @(negedge clk);
        bus.req_valid = 4'b1000;
        bus.rd_req    = 1'b1;
        #1;
        checks++; if (bus.wr_en !== 1'b1) begin errors++; $display("FAIL b2b_wr_en got %0h want 1", bus.wr_en); end
        checks++; if (bus.rd_en !== 1'b1) begin errors++; $display("FAIL b2b_rd_en got %0h want 1", bus.rd_en); end
        checks++; if (bus.grant_id !== 2'd3) begin errors++; $display("FAIL b2b_grant_id got %0d want 3", bus.grant_id); end
        @(posedge clk);
        #1;
        checks++; if (bus.empty !== 1'b0) begin errors++; $display("FAIL b2b_count_held got %0h want 0", bus.empty); end
        checks++; if (bus.wr_ptr !== 3'd3) begin errors++; $display("FAIL b2b_wr_ptr got %0d want 3", bus.wr_ptr); end
        checks++; if (bus.rd_ptr !== 3'd2) begin errors++; $display("FAIL b2b_rd_ptr got %0d want 2", bus.rd_ptr); end
        @(negedge clk);
        bus.req_valid = '0;
        @(posedge clk);
        #1;
        bus.rd_req = 1'b0;
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL b2b_empty_after_pop got %0h want 1", bus.empty); end
        checks++; if (bus.rd_ptr !== 3'd3) begin errors++; $display("FAIL b2b_rd_ptr_final got %0d want 3", bus.rd_ptr); end
    endtask

    task automatic test_midop_reset();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.req_valid = 4'b1111;
            @(posedge clk);
            #1;
        end
        checks++; if (bus.wr_ptr !== 3'd5) begin errors++; $display("FAIL mid_pre_wr_ptr got %0d want 5", bus.wr_ptr); end
        @(negedge clk);
        sreset = 1'b1;
        @(posedge clk);
        #1;
        sreset = 1'b0;
        checks++; if (bus.wr_ptr !== 3'd0) begin errors++; $display("FAIL mid_wr_ptr got %0d want 0", bus.wr_ptr); end
        checks++; if (bus.rd_ptr !== 3'd0) begin errors++; $display("FAIL mid_rd_ptr got %0d want 0", bus.rd_ptr); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL mid_empty got %0h want 1", bus.empty); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL mid_full got %0h want 0", bus.full); end
        @(negedge clk);
        #1;
        checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL mid_first_grant got %0d want 0", bus.grant_id); end
        bus.req_valid = '0;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        sreset        = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        bus.rd_req    = 1'b0;
        test_reset();
        test_round_robin();
        test_fill();
        test_full_read();
        test_empty_both();
        test_back_to_back();
        test_midop_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
